// File: rtl/onehot_phase_decoder.sv
// Registered phase index with step/jump control and a one-hot phase decode.
// Advancing past LAST wraps to 0; loads beyond LAST park the index at 0 and flag err.
module onehot_phase_decoder #(
    parameter  int SEL_W   = 3,
    parameter  int LAST    = 4,
    parameter  int RST_IDX = 0,
    localparam int OUT_W   = 2**SEL_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [SEL_W-1:0] sel,
    input  logic             adv,
    output logic [OUT_W-1:0] phase,
    output logic [SEL_W-1:0] idx,
    output logic             wrap,
    output logic             err
);

    localparam logic [SEL_W-1:0] LAST_C = LAST[SEL_W-1:0];
    localparam logic [SEL_W-1:0] RST_C  = RST_IDX[SEL_W-1:0];
    localparam logic [SEL_W-1:0] ZERO_C = {SEL_W{1'b0}};
    localparam logic [SEL_W-1:0] INC_C  = {{(SEL_W-1){1'b0}}, 1'b1};
    localparam logic [OUT_W-1:0] ONE_C  = {{(OUT_W-1){1'b0}}, 1'b1};

    logic [SEL_W-1:0] r_idx;
    logic             r_wrap;
    logic             r_err;
    logic [SEL_W-1:0] w_idx_nxt;
    logic             w_wrap_nxt;
    logic             w_err_nxt;

    // Next-state selection: en gates everything, load outranks adv.
    always_comb begin
        w_idx_nxt  = r_idx;
        w_wrap_nxt = 1'b0;
        w_err_nxt  = 1'b0;
        if (!en) begin
            w_idx_nxt = r_idx;
        end else if (load) begin
            if (sel > LAST_C) begin
                w_idx_nxt = ZERO_C;
                w_err_nxt = 1'b1;
            end else begin
                w_idx_nxt = sel;
            end
        end else if (adv) begin
            if (r_idx == LAST_C) begin
                w_idx_nxt  = ZERO_C;
                w_wrap_nxt = 1'b1;
            end else begin
                w_idx_nxt = r_idx + INC_C;
            end
        end else begin
            w_idx_nxt = r_idx;
        end
    end

    // State and pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx  <= RST_C;
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_idx  <= w_idx_nxt;
            r_wrap <= w_wrap_nxt;
            r_err  <= w_err_nxt;
        end
    end

    assign phase = ONE_C << r_idx;
    assign idx   = r_idx;
    assign wrap  = r_wrap;
    assign err   = r_err;

endmodule
